// File: rtl/fir_out_pkg.sv
// Shared constants and helpers for the FIR output decimate/round/saturate stage.
package fir_out_pkg;

    localparam int DROP_CNT_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; dout is the head entry, read combinationally.
module sync_fifo
    import fir_out_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fir_out_decim_sat.sv
// Decimates FIR output, round-half-up scales and saturates it, then buffers behind valid/ready.
module fir_out_decim_sat
    import fir_out_pkg::*;
#(
    parameter int IN_WIDTH   = 28,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 8,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   y,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_sticky,
    input  logic                  clear_sat,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int              PH_W    = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam int              SW      = IN_WIDTH + 1;
    // Half an output LSB; collapses to zero when SHIFT is 0.
    localparam logic [SW-1:0]   RND     = (SW'(1) << SHIFT) >> 1;
    localparam logic [63:0]     SAT_MAX = sat_max(OUT_WIDTH);

    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [OUT_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic                  sat_sticky_q, sat_sticky_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

    logic                  keep;
    logic [SW-1:0]         sum;
    logic [SW-1:0]         scaled;
    logic                  sat_hit;
    logic [OUT_WIDTH-1:0]  result;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, drop;

    always_comb begin
        keep    = in_valid && (phase_q == '0);
        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        sum     = {1'b0, y} + RND;
        scaled  = sum >> SHIFT;
        sat_hit = 64'(scaled) > SAT_MAX;
        result  = sat_hit ? OUT_WIDTH'(SAT_MAX) : OUT_WIDTH'(scaled);

        s1_valid_d = keep;
        s1_data_d  = keep ? result : s1_data_q;

        sat_sticky_d = sat_sticky_q;
        if (clear_sat) begin
            sat_sticky_d = 1'b0;
        end
        if (keep && sat_hit) begin
            sat_sticky_d = 1'b1;
        end

        // The FIR cannot stall, so a stage-1 sample with nowhere to go is discarded.
        pop  = !fifo_empty && out_ready;
        push = s1_valid_q && (!fifo_full || pop);
        drop = s1_valid_q && fifo_full && !pop;

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            sat_sticky_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            phase_q      <= phase_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            sat_sticky_q <= sat_sticky_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH(OUT_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (s1_data_q),
        .dout (out_data),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign sat_sticky = sat_sticky_q;
    assign drop_count = drop_count_q;

endmodule
